tmr_fault_monitor: RTL and testbench

//  Sequential supervisor directly downstream of the TMR writeback voter. Samples the

---
 rtl/tmr_fault_monitor.sv | 128 ++++++++++++
 tb/tb_tmr_fault_monitor.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/tmr_fault_monitor.sv
// Supervisor downstream of the TMR writeback voter: counts per-lane faults, detects
// persistent lane faults, requests resync, and halts when majority voting is lost.
module tmr_fault_monitor #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned PERSIST_TH = 4,
  parameter int unsigned TIMEOUT    = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_valid,
  input  logic             fault_A,
  input  logic             fault_B,
  input  logic             fault_C,
  input  logic             system_fault,
  input  logic             resync_done,
  output logic             resync_req,
  output logic [2:0]       failed_lanes,
  output logic             halt,
  output logic [CNT_W-1:0] err_cnt_A,
  output logic [CNT_W-1:0] err_cnt_B,
  output logic [CNT_W-1:0] err_cnt_C,
  output logic [1:0]       fsm_state
);

  localparam int unsigned CW = $clog2(PERSIST_TH + 1);
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] MONITOR = 2'b00;
  localparam logic [1:0] RESYNC  = 2'b01;
  localparam logic [1:0] HALT    = 2'b10;

  logic [1:0]       state;
  logic [2:0]       fault;
  logic [2:0]       hit;
  logic             multi_hit;
  logic [2:0]       failed;
  logic [CW-1:0]    consec [3];
  logic [CNT_W-1:0] err_cnt [3];
  logic [TW-1:0]    tmo;
  logic             resync_q;
  logic             halt_q;

  // A lane "hits" when this faulty writeback brings its run length to PERSIST_TH.
  always_comb begin
    fault = {fault_C, fault_B, fault_A};
    hit   = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      hit[i] = fault[i] && (consec[i] >= CW'(PERSIST_TH - 1));
    end
    multi_hit = (hit[0] & hit[1]) | (hit[0] & hit[2]) | (hit[1] & hit[2]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= MONITOR;
      failed   <= '0;
      resync_q <= 1'b0;
      halt_q   <= 1'b0;
      tmo      <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        consec[i]  <= '0;
        err_cnt[i] <= '0;
      end
    end else begin
      case (state)
        MONITOR: begin
          if (wb_valid) begin
            for (int unsigned i = 0; i < 3; i++) begin
              if (fault[i] && (err_cnt[i] != '1)) begin
                err_cnt[i] <= err_cnt[i] + CNT_W'(1);
              end
              if (!fault[i])   consec[i] <= '0;
              else if (hit[i]) consec[i] <= CW'(PERSIST_TH);
              else             consec[i] <= consec[i] + CW'(1);
            end
            if (system_fault) begin
              state  <= HALT;
              halt_q <= 1'b1;
              failed <= 3'b111;
            end else if (multi_hit) begin
              state  <= HALT;
              halt_q <= 1'b1;
              failed <= failed | hit;
            end else if (|hit) begin
              state    <= RESYNC;
              resync_q <= 1'b1;
              failed   <= failed | hit;
              tmo      <= '0;
            end
          end
        end
        RESYNC: begin
          if (resync_done) begin
            state    <= MONITOR;
            resync_q <= 1'b0;
            failed   <= '0;
            tmo      <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
              consec[i] <= '0;
            end
          end else if (tmo == TW'(TIMEOUT - 1)) begin
            state    <= HALT;
            resync_q <= 1'b0;
            halt_q   <= 1'b1;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end
        HALT: begin
        end
        default: begin
          state    <= HALT;
          resync_q <= 1'b0;
          halt_q   <= 1'b1;
        end
      endcase
    end
  end

  assign resync_req   = resync_q;
  assign halt         = halt_q;
  assign failed_lanes = failed;
  assign err_cnt_A    = err_cnt[0];
  assign err_cnt_B    = err_cnt[1];
  assign err_cnt_C    = err_cnt[2];
  assign fsm_state    = state;

endmodule

// File: tb/tb_tmr_fault_monitor.sv
// Directed bench for tmr_fault_monitor with small parameters so saturation and
// timeout boundaries are reachable in a short run.
module tb_tmr_fault_monitor;

  localparam int unsigned CNT_W      = 3;
  localparam int unsigned PERSIST_TH = 4;
  localparam int unsigned TIMEOUT    = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             wb_valid;
  logic             fault_A, fault_B, fault_C;
  logic             system_fault;
  logic             resync_done;
  logic             resync_req;
  logic [2:0]       failed_lanes;
  logic             halt;
  logic [CNT_W-1:0] err_cnt_A, err_cnt_B, err_cnt_C;
  logic [1:0]       fsm_state;

  int checks   = 0;
  int failures = 0;

  tmr_fault_monitor #(
    .CNT_W     (CNT_W),
    .PERSIST_TH(PERSIST_TH),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wb_valid    (wb_valid),
    .fault_A     (fault_A),
    .fault_B     (fault_B),
    .fault_C     (fault_C),
    .system_fault(system_fault),
    .resync_done (resync_done),
    .resync_req  (resync_req),
    .failed_lanes(failed_lanes),
    .halt        (halt),
    .err_cnt_A   (err_cnt_A),
    .err_cnt_B   (err_cnt_B),
    .err_cnt_C   (err_cnt_C),
    .fsm_state   (fsm_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic wb(input logic a, input logic b, input logic c, input logic sf, input logic v);
    wb_valid = v; fault_A = a; fault_B = b; fault_C = c; system_fault = sf;
    tick();
    wb_valid = 1'b0; fault_A = 1'b0; fault_B = 1'b0; fault_C = 1'b0; system_fault = 1'b0;
  endtask

  task automatic pulse_done();
    resync_done = 1'b1;
    tick();
    resync_done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_state"},  32'(fsm_state),    32'h0);
    check({tag, "_failed"}, 32'(failed_lanes), 32'h0);
    check({tag, "_req"},    32'(resync_req),   32'h0);
    check({tag, "_halt"},   32'(halt),         32'h0);
    check({tag, "_errA"},   32'(err_cnt_A),    32'h0);
    check({tag, "_errB"},   32'(err_cnt_B),    32'h0);
    check({tag, "_errC"},   32'(err_cnt_C),    32'h0);
  endtask

  initial begin
    rst = 1'b1; wb_valid = 1'b0; fault_A = 1'b0; fault_B = 1'b0; fault_C = 1'b0;
    system_fault = 1'b0; resync_done = 1'b0;
    idle(2);
    rst = 1'b0;
    check_idle("reset");

    // Clean writebacks leave everything at zero
    for (int k = 0; k < 10; k++) wb(0, 0, 0, 0, 1);
    check_idle("clean10");

    // Broken fault run on B never persists; then saturate B at 7
    for (int k = 0; k < 3; k++) wb(0, 1, 0, 0, 1);
    wb(0, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) wb(0, 1, 0, 0, 1);
    check("runB_err", 32'(err_cnt_B), 32'd6);
    check("runB_req", 32'(resync_req), 32'h0);
    check("runB_state", 32'(fsm_state), 32'h0);
    wb(0, 0, 0, 0, 1);
    wb(0, 1, 0, 0, 1);
    wb(0, 1, 0, 0, 1);
    check("satB_err", 32'(err_cnt_B), 32'd7);
    check("satB_errA", 32'(err_cnt_A), 32'd0);
    wb(0, 0, 0, 0, 1);

    // Persistent C fault -> RESYNC, then recovery
    do_reset();
    for (int k = 0; k < 3; k++) wb(0, 0, 1, 0, 1);
    check("C3_state", 32'(fsm_state), 32'h0);
    check("C3_req", 32'(resync_req), 32'h0);
    wb(0, 0, 1, 0, 1);
    check("C4_failed", 32'(failed_lanes), 32'b100);
    check("C4_req", 32'(resync_req), 32'h1);
    check("C4_state", 32'(fsm_state), 32'b01);
    wb(1, 1, 1, 0, 1);
    check("resync_frozen_errC", 32'(err_cnt_C), 32'd4);
    check("resync_frozen_errA", 32'(err_cnt_A), 32'd0);
    pulse_done();
    check("done_state", 32'(fsm_state), 32'h0);
    check("done_failed", 32'(failed_lanes), 32'h0);
    check("done_req", 32'(resync_req), 32'h0);
    check("done_errC", 32'(err_cnt_C), 32'd4);
    wb(0, 0, 1, 0, 1);
    check("consec_cleared_state", 32'(fsm_state), 32'h0);
    check("consec_cleared_errC", 32'(err_cnt_C), 32'd5);
    pulse_done();
    check("done_in_monitor", 32'(fsm_state), 32'h0);

    // Two lanes persistent together -> HALT
    do_reset();
    for (int k = 0; k < 4; k++) wb(1, 1, 0, 0, 1);
    check("AB_failed", 32'(failed_lanes), 32'b011);
    check("AB_halt", 32'(halt), 32'h1);
    check("AB_state", 32'(fsm_state), 32'b10);
    check("AB_req", 32'(resync_req), 32'h0);
    wb(1, 1, 1, 1, 1);
    pulse_done();
    check("halt_frozen_failed", 32'(failed_lanes), 32'b011);
    check("halt_frozen_errA", 32'(err_cnt_A), 32'd4);
    check("halt_frozen_errC", 32'(err_cnt_C), 32'd0);
    check("halt_sticky", 32'(halt), 32'h1);
    do_reset();
    check_idle("halt_rst");

    // system_fault only counts on a valid writeback
    wb(0, 0, 0, 1, 0);
    check("sf_novalid_halt", 32'(halt), 32'h0);
    check("sf_novalid_failed", 32'(failed_lanes), 32'h0);
    wb(0, 0, 0, 1, 1);
    check("sf_halt", 32'(halt), 32'h1);
    check("sf_failed", 32'(failed_lanes), 32'b111);
    check("sf_state", 32'(fsm_state), 32'b10);

    // Resync timeout after exactly TIMEOUT cycles in RESYNC
    do_reset();
    for (int k = 0; k < 4; k++) wb(1, 0, 0, 0, 1);
    check("A4_state", 32'(fsm_state), 32'b01);
    idle(TIMEOUT - 1);
    check("tmo_edge_minus1_state", 32'(fsm_state), 32'b01);
    idle(1);
    check("tmo_state", 32'(fsm_state), 32'b10);
    check("tmo_req", 32'(resync_req), 32'h0);
    check("tmo_halt", 32'(halt), 32'h1);
    check("tmo_failed", 32'(failed_lanes), 32'b001);

    // resync_done on the timeout edge wins
    do_reset();
    for (int k = 0; k < 4; k++) wb(1, 0, 0, 0, 1);
    idle(TIMEOUT - 1);
    pulse_done();
    check("tmo_done_state", 32'(fsm_state), 32'h0);
    check("tmo_done_halt", 32'(halt), 32'h0);

    // rst in the middle of RESYNC
    do_reset();
    for (int k = 0; k < 4; k++) wb(0, 1, 0, 0, 1);
    idle(3);
    check("mid_state", 32'(fsm_state), 32'b01);
    do_reset();
    check_idle("mid_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
